// File: rtl/vga_frame_streamer.sv
// 640x480@60 VGA scan-out: raster timing, one FIFO pop per active pixel, RGB unpack and pin alignment.
// Optional macro VGA_TEST_PATTERN_EN: idle frames show 8 vertical colour bars instead of black.
module vga_frame_streamer #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   input  logic [15:0] i_data1,
   input  logic [15:0] i_data2,
   output logic        o_request,
   output logic [7:0]  o_VGA_R,
   output logic [7:0]  o_VGA_G,
   output logic [7:0]  o_VGA_B,
   output logic        o_H_sync,
   output logic        o_V_sync,
   output logic        o_VGA_BLANK_N,
   output logic        o_frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW = $clog2(H_TOTAL);
   localparam int unsigned VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] HLast  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HAct   = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HsBeg  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HsEnd  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] VLast  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VAct   = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VsBeg  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VsEnd  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef struct packed {
      logic          act;
      logic          hs_n;
      logic          vs_n;
      logic          req;
`ifdef VGA_TEST_PATTERN_EN
      logic [HW-1:0] h;
`endif
   } tap_t;

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          frm_en_q, frm_en_d;
   tap_t          dly_q [RD_LAT];
   tap_t          dly_d [RD_LAT];
   tap_t          tap;
   logic [23:0]   rgb_q, rgb_d;
   logic [23:0]   idle_rgb;
   logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
   logic          at_origin, act, req;
   logic          unused_bits;

   assign unused_bits = ^{i_data1[15], i_data1[1:0], i_data2[15], i_data2[11:10], i_data2[1:0]};

   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == HLast) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
      end
   end

   always_comb begin
      at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
      act       = (h_cnt_q < HAct) && (v_cnt_q < VAct);
      // At (0,0) the live i_en decides, so the first pixel of a frame is not lost.
      req       = act && (at_origin ? i_en : frm_en_q);
      frm_en_d  = at_origin ? i_en : frm_en_q;
      // Gated by reset so these combinational outputs sit at their reset value while held.
      o_request     = i_rst_n && req;
      o_frame_start = i_rst_n && at_origin;
   end

   always_comb begin
      dly_d[0]      = '0;
      dly_d[0].act  = act;
      dly_d[0].hs_n = !((h_cnt_q >= HsBeg) && (h_cnt_q <= HsEnd));
      dly_d[0].vs_n = !((v_cnt_q >= VsBeg) && (v_cnt_q <= VsEnd));
      dly_d[0].req  = req;
`ifdef VGA_TEST_PATTERN_EN
      dly_d[0].h    = h_cnt_q;
`endif
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         dly_d[i] = dly_q[i-1];
      end
      tap = dly_q[RD_LAT-1];
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [HW-1:0] BarW = HW'(H_ACTIVE / 8);
   logic [2:0] bar;
   always_comb begin
      bar = 3'(tap.h / BarW);
      // Bar index bits map directly to which components are off.
      idle_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
   end
`else
   assign idle_rgb = '0;
`endif

   always_comb begin
      rgb_d   = '0;
      if (tap.act) begin
         rgb_d = tap.req ? {i_data1[9:2], i_data1[14:10], i_data2[14:12], i_data2[9:2]} : idle_rgb;
      end
      hs_d    = tap.hs_n;
      vs_d    = tap.vs_n;
      blank_d = tap.act;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         frm_en_q <= 1'b0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            dly_q[i]      <= '0;
            dly_q[i].hs_n <= 1'b1;
            dly_q[i].vs_n <= 1'b1;
         end
         rgb_q    <= '0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         blank_q  <= 1'b0;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         frm_en_q <= frm_en_d;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            dly_q[i] <= dly_d[i];
         end
         rgb_q    <= rgb_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         blank_q  <= blank_d;
      end
   end

   assign o_VGA_R       = rgb_q[23:16];
   assign o_VGA_G       = rgb_q[15:8];
   assign o_VGA_B       = rgb_q[7:0];
   assign o_H_sync      = hs_q;
   assign o_V_sync      = vs_q;
   assign o_VGA_BLANK_N = blank_q;

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Bench for vga_frame_streamer: a shrunk-raster instance checked cycle by cycle against a raster
// model, plus a full-size instance checked over its first line.
module tb_vga_frame_streamer;

   localparam int HA = 16, HF = 2, HS = 4, HB = 3;
   localparam int VA = 8, VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_en;
   logic        en2 = 1'b1;
   logic [15:0] i_data1, i_data2;
   logic        o_request, o_H_sync, o_V_sync, o_VGA_BLANK_N, o_frame_start;
   logic [7:0]  o_VGA_R, o_VGA_G, o_VGA_B;
   logic        req2, hs2, vs2, blank2, fs2;
   logic [7:0]  r2, g2, b2;

   int checks = 0, failures = 0;
   int c;
   logic        frm_en_m;
   logic [15:0] d1_h [4096];
   logic [15:0] d2_h [4096];
   logic        req_h [4096];
   int          frame_req [8];
   int          req2_cnt, hs2_low, blank2_cnt, hs2_fall;

   always #5 i_clk = ~i_clk;

   vga_frame_streamer #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RD_LAT(1)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_data1(i_data1), .i_data2(i_data2),
      .o_request(o_request), .o_VGA_R(o_VGA_R), .o_VGA_G(o_VGA_G), .o_VGA_B(o_VGA_B),
      .o_H_sync(o_H_sync), .o_V_sync(o_V_sync), .o_VGA_BLANK_N(o_VGA_BLANK_N),
      .o_frame_start(o_frame_start)
   );

   vga_frame_streamer dut_full (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(en2), .i_data1(i_data1), .i_data2(i_data2),
      .o_request(req2), .o_VGA_R(r2), .o_VGA_G(g2), .o_VGA_B(b2),
      .o_H_sync(hs2), .o_V_sync(vs2), .o_VGA_BLANK_N(blank2), .o_frame_start(fs2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, got, exp);
      end
   endtask

   function automatic logic act_at(input int p);
      return ((p % HT) < HA) && (((p / HT) % VT) < VA);
   endfunction

   function automatic logic hs_at(input int p);
      return !(((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS));
   endfunction

   function automatic logic vs_at(input int p);
      return !((((p / HT) % VT) >= VA + VF) && (((p / HT) % VT) < VA + VF + VS));
   endfunction

   function automatic logic [23:0] idle_at(input int p);
`ifdef VGA_TEST_PATTERN_EN
      logic [23:0] bars [8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      return bars[(p % HT) / (HA / 8)];
`else
      return (p < 0) ? 24'h1 : 24'h0;
`endif
   endfunction

   function automatic logic [23:0] unpack(input logic [15:0] d1, input logic [15:0] d2);
      return {d1[9:2], d1[14:10], d2[14:12], d2[9:2]};
   endfunction

   task automatic release_reset();
      i_rst_n = 1'b1;
      c = 0;
      frm_en_m = 1'b0;
      req2_cnt = 0; hs2_low = 0; blank2_cnt = 0; hs2_fall = -1;
      for (int i = 0; i < 8; i++) frame_req[i] = 0;
   endtask

   task automatic check_reset_pins(input string tag);
      chk({tag, "_req"}, {31'd0, o_request}, 32'd0);
      chk({tag, "_fs"}, {31'd0, o_frame_start}, 32'd0);
      chk({tag, "_pins"}, {5'd0, o_VGA_BLANK_N, o_H_sync, o_V_sync, o_VGA_R, o_VGA_G, o_VGA_B},
          {5'd0, 3'b011, 24'h0});
   endtask

   task automatic step();
      logic [15:0] d1, d2;
      logic        exp_req;
      logic [26:0] exp_pins;
      int          p;
      d1 = 16'($urandom);
      d2 = 16'($urandom);
      if (c == 27) begin d1 = 16'h7FFC; d2 = 16'h0000; end
      if (c == 28) begin d1 = 16'h0000; d2 = 16'h7FFC; end
      i_data1 = d1; i_data2 = d2;
      d1_h[c] = d1; d2_h[c] = d2;
      #1;
      if (c % FT == 0) frm_en_m = i_en;
      exp_req = act_at(c) && frm_en_m;
      req_h[c] = exp_req;
      chk("request", {31'd0, o_request}, {31'd0, exp_req});
      chk("frame_start", {31'd0, o_frame_start}, {31'd0, (c % FT == 0)});
      if (c < 2) begin
         exp_pins = {3'b011, 24'h0};
      end else begin
         p = c - 2;
         exp_pins = {act_at(p), hs_at(p), vs_at(p), 24'h0};
         if (act_at(p)) exp_pins[23:0] = req_h[p] ? unpack(d1_h[p+1], d2_h[p+1]) : idle_at(p);
      end
      chk("pins", {5'd0, o_VGA_BLANK_N, o_H_sync, o_V_sync, o_VGA_R, o_VGA_G, o_VGA_B},
          {5'd0, exp_pins});
      if (c == 28) chk("unpack_g", {8'd0, o_VGA_R, o_VGA_G, o_VGA_B}, 32'h00FFF800);
      if (c == 29) chk("unpack_b", {8'd0, o_VGA_R, o_VGA_G, o_VGA_B}, 32'h000007FF);
      if (o_request === 1'b1 && c / FT < 8) frame_req[c / FT]++;
      if (c < 800) begin
         if (req2 === 1'b1) req2_cnt++;
         if (hs2 === 1'b0) hs2_low++;
         if (blank2 === 1'b1) blank2_cnt++;
         if (hs2 === 1'b0 && hs2_fall < 0) hs2_fall = c;
      end
      @(posedge i_clk);
      #1;
      c++;
   endtask

   task automatic run_to(input int last, input bit rnd_en);
      while (c < last) begin
         if (rnd_en && $urandom_range(0, 39) == 0) i_en = ~i_en;
         step();
      end
   endtask

   task automatic check_full_line();
      chk("full_line_requests", req2_cnt, 640);
      chk("full_hsync_low", hs2_low, 96);
      chk("full_blank_high", blank2_cnt, 640);
      chk("full_hsync_fall", hs2_fall, 658);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_en = 1'b1;
      i_data1 = '0;
      i_data2 = '0;
      c = 0;
      repeat (3) @(posedge i_clk);
      #1;
      check_reset_pins("reset");
      release_reset();

      // Enabled frame, i_en dropped on line 3; idle frame; late enable at h=5 of frame 2.
      run_to(3 * HT, 1'b0);
      i_en = 1'b0;
      run_to(2 * FT + 5, 1'b0);
      i_en = 1'b1;
      run_to(4 * FT + 4 * HT + 10, 1'b0);
      chk("frame0_requests", frame_req[0], HA * VA);
      chk("frame1_requests", frame_req[1], 0);
      chk("frame2_requests", frame_req[2], 0);
      chk("frame3_requests", frame_req[3], HA * VA);
      check_full_line();

      // Asynchronous reset mid-line: no clock edge between assertion and check.
      chk("pre_reset_req", {31'd0, o_request}, 32'd1);
      i_rst_n = 1'b0;
      #1;
      check_reset_pins("async_reset");
      repeat (2) @(posedge i_clk);
      #1;
      release_reset();
      run_to(3 * FT + 50, 1'b1);
      check_full_line();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
